// File: rtl/sme_pkg.sv
// Shared definitions for the SME byte-stream driver: character codes, buffer depths,
// FSM state encoding and the result-index helper.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 10;
    localparam int IDX_W   = 5;

    localparam logic [7:0] CHAR_CARET  = 8'h5E;
    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam logic [7:0] CHAR_DOT    = 8'h2E;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_SEND_PAT = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4
    } sme_state_t;

    // A match index is only meaningful when the SME reported a match.
    function automatic logic [IDX_W-1:0] result_idx(input logic match,
                                                    input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        if (match) begin
            r = idx;
        end else begin
            r = {IDX_W{1'b0}};
        end
        return r;
    endfunction

endpackage

// File: rtl/sme_stream_driver_if.sv
// Host and SME facing signals of the stream driver. master = the driver itself,
// slave = the environment (host plus SME core).
interface sme_stream_driver_if;

    logic                      clr;
    logic                      wr_en;
    logic                      wr_sel;
    logic [7:0]                wr_data;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      result_match;
    logic [sme_pkg::IDX_W-1:0] result_index;
    logic                      timeout_err;
    logic                      overflow;
    logic [7:0]                chardata;
    logic                      isstring;
    logic                      ispattern;
    logic                      sme_valid;
    logic                      sme_match;
    logic [sme_pkg::IDX_W-1:0] sme_match_index;

    modport master (
        input  clr, wr_en, wr_sel, wr_data, start,
        input  sme_valid, sme_match, sme_match_index,
        output busy, done, result_match, result_index, timeout_err, overflow,
        output chardata, isstring, ispattern
    );

    modport slave (
        output clr, wr_en, wr_sel, wr_data, start,
        output sme_valid, sme_match, sme_match_index,
        input  busy, done, result_match, result_index, timeout_err, overflow,
        input  chardata, isstring, ispattern
    );

endinterface

// File: rtl/sme_byte_buf.sv
// Depth x 8 register file filled in order; the length doubles as the write pointer.
module sme_byte_buf #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [LW-1:0] len,
    output logic          full
);

    logic [7:0]    mem_r [DEPTH];
    logic [LW-1:0] len_r;
    logic [7:0]    rd_data_s;

    assign full    = (len_r == LW'(DEPTH));
    assign len     = len_r;
    assign rd_data = rd_data_s;

    // Append-only storage; writes into a full buffer are dropped here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r <= {LW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (clr) begin
            len_r <= {LW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en && !full) begin
            mem_r[len_r[AW-1:0]] <= wr_data;
            len_r                <= len_r + {{(LW-1){1'b0}}, 1'b1};
        end
    end

    // Asynchronous read port, zero for addresses past the physical depth.
    always_comb begin
        rd_data_s = 8'h00;
        if (int'(rd_addr) < DEPTH) begin
            rd_data_s = mem_r[rd_addr];
        end else begin
            rd_data_s = 8'h00;
        end
    end

endmodule

// File: rtl/sme_stream_driver.sv
// Transmit side of the SME byte interface: streams the buffered string and pattern,
// then waits (bounded) for the SME verdict and reports it with a done pulse.
module sme_stream_driver
    import sme_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sme_stream_driver_if.master  bus
);

    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [SLW-1:0] IDX_ONE = {{(SLW-1){1'b0}}, 1'b1};

    sme_state_t       state_r;
    logic [SLW-1:0]   rd_idx_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic             str_dirty_r;
    logic             busy_r;
    logic             done_r;
    logic             result_match_r;
    logic [IDX_W-1:0] result_index_r;
    logic             timeout_err_r;
    logic             overflow_r;
    logic [7:0]       chardata_r;
    logic             isstring_r;
    logic             ispattern_r;

    logic             clr_acc_s;
    logic             wr_acc_s;
    logic             start_acc_s;
    logic             str_wr_s;
    logic             pat_wr_s;
    logic             pat_clr_s;
    logic             sel_full_s;
    logic [SAW-1:0]   str_rd_addr_s;
    logic [PAW-1:0]   pat_rd_addr_s;
    logic [7:0]       str_rd_data_s;
    logic [7:0]       pat_rd_data_s;
    logic [SLW-1:0]   str_len_s;
    logic [PLW-1:0]   pat_len_s;
    logic             str_full_s;
    logic             pat_full_s;

    // Host requests are honoured only in IDLE; clr outranks start and wr_en.
    always_comb begin
        clr_acc_s     = 1'b0;
        wr_acc_s      = 1'b0;
        start_acc_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            clr_acc_s   = bus.clr;
            wr_acc_s    = !bus.clr && bus.wr_en;
            start_acc_s = !bus.clr && bus.start && (pat_len_s != {PLW{1'b0}});
        end else begin
            clr_acc_s   = 1'b0;
        end
        str_wr_s      = wr_acc_s && !bus.wr_sel;
        pat_wr_s      = wr_acc_s && bus.wr_sel;
        sel_full_s    = bus.wr_sel ? pat_full_s : str_full_s;
        // The SME consumes the pattern, so it is dropped as the transaction retires.
        pat_clr_s     = clr_acc_s || (state_r == ST_DONE);
        str_rd_addr_s = (state_r == ST_SEND_STR) ? rd_idx_r[SAW-1:0] : {SAW{1'b0}};
        pat_rd_addr_s = (state_r == ST_SEND_PAT) ? rd_idx_r[PAW-1:0] : {PAW{1'b0}};
    end

    sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_acc_s),
        .wr_en   (str_wr_s),
        .wr_data (bus.wr_data),
        .rd_addr (str_rd_addr_s),
        .rd_data (str_rd_data_s),
        .len     (str_len_s),
        .full    (str_full_s)
    );

    sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (pat_clr_s),
        .wr_en   (pat_wr_s),
        .wr_data (bus.wr_data),
        .rd_addr (pat_rd_addr_s),
        .rd_data (pat_rd_data_s),
        .len     (pat_len_s),
        .full    (pat_full_s)
    );

    // Transaction FSM; every output is set one edge ahead of the cycle it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            rd_idx_r       <= {SLW{1'b0}};
            wait_cnt_r     <= {WCW{1'b0}};
            str_dirty_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_match_r <= 1'b0;
            result_index_r <= {IDX_W{1'b0}};
            timeout_err_r  <= 1'b0;
            overflow_r     <= 1'b0;
            chardata_r     <= 8'h00;
            isstring_r     <= 1'b0;
            ispattern_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_acc_s) begin
                        str_dirty_r <= 1'b0;
                        overflow_r  <= 1'b0;
                    end else begin
                        if (wr_acc_s) begin
                            if (sel_full_s) begin
                                overflow_r <= 1'b1;
                            end else if (!bus.wr_sel) begin
                                str_dirty_r <= 1'b1;
                            end
                        end
                        if (start_acc_s) begin
                            busy_r   <= 1'b1;
                            rd_idx_r <= IDX_ONE;
                            // A clean string is still held by the SME and is not resent.
                            if (str_dirty_r && (str_len_s != {SLW{1'b0}})) begin
                                state_r    <= ST_SEND_STR;
                                isstring_r <= 1'b1;
                                chardata_r <= str_rd_data_s;
                            end else begin
                                state_r     <= ST_SEND_PAT;
                                ispattern_r <= 1'b1;
                                chardata_r  <= pat_rd_data_s;
                            end
                        end
                    end
                end
                ST_SEND_STR: begin
                    if (rd_idx_r == str_len_s) begin
                        state_r     <= ST_SEND_PAT;
                        isstring_r  <= 1'b0;
                        ispattern_r <= 1'b1;
                        chardata_r  <= pat_rd_data_s;
                        str_dirty_r <= 1'b0;
                        rd_idx_r    <= IDX_ONE;
                    end else begin
                        chardata_r <= str_rd_data_s;
                        rd_idx_r   <= rd_idx_r + IDX_ONE;
                    end
                end
                ST_SEND_PAT: begin
                    if (rd_idx_r == {{(SLW-PLW){1'b0}}, pat_len_s}) begin
                        state_r     <= ST_WAIT;
                        ispattern_r <= 1'b0;
                        wait_cnt_r  <= {WCW{1'b0}};
                    end else begin
                        chardata_r <= pat_rd_data_s;
                        rd_idx_r   <= rd_idx_r + IDX_ONE;
                    end
                end
                ST_WAIT: begin
                    if (bus.sme_valid) begin
                        state_r        <= ST_DONE;
                        result_match_r <= bus.sme_match;
                        result_index_r <= result_idx(bus.sme_match, bus.sme_match_index);
                        timeout_err_r  <= 1'b0;
                        done_r         <= 1'b1;
                        busy_r         <= 1'b0;
                    end else if (wait_cnt_r == WCW'(TIMEOUT - 1)) begin
                        state_r        <= ST_DONE;
                        result_match_r <= 1'b0;
                        result_index_r <= {IDX_W{1'b0}};
                        timeout_err_r  <= 1'b1;
                        done_r         <= 1'b1;
                        busy_r         <= 1'b0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    isstring_r  <= 1'b0;
                    ispattern_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.result_match = result_match_r;
    assign bus.result_index = result_index_r;
    assign bus.timeout_err  = timeout_err_r;
    assign bus.overflow     = overflow_r;
    assign bus.chardata     = chardata_r;
    assign bus.isstring     = isstring_r;
    assign bus.ispattern    = ispattern_r;

endmodule
